// File: rtl/fifo_pkg.sv
// Shared helpers for the multi-lane FIFO: word sizing, pointer wrap and
// the replay-control priority encoding.
package fifo_pkg;

  typedef enum logic [1:0] {
    CTL_NONE,
    CTL_MARK,
    CTL_RELEASE,
    CTL_REWIND
  } ctl_e;

  function automatic int unsigned word_w(input int unsigned dw, input int unsigned nch);
    return dw * nch;
  endfunction

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM: synchronous write, registered read that returns
// zero on cycles without a read enable.
module fifo_sdp_ram #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4608
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst)
      rd_data <= '0;
    else if (rd_en)
      rd_data <= mem[rd_addr];
    else
      rd_data <= '0;
  end

endmodule

// File: rtl/fifo_multi_ch.sv
// Multi-lane FIFO with occupancy/status flags and a mark/rewind/release
// replay window so the consumer can re-read a block without a resend.
module fifo_multi_ch
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4,
  parameter int DEPTH      = 4608
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [NUM_CH*DATA_WIDTH-1:0] wr_data,
  input  logic                         rd_en,
  input  logic                         rd_mark,
  input  logic                         rd_rewind,
  input  logic                         rd_release,
  output logic [NUM_CH*DATA_WIDTH-1:0] rd_data,
  output logic                         rd_valid,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [$clog2(DEPTH+1)-1:0]   rd_count,
  output logic                         ovf,
  output logic                         udf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = word_w(DATA_WIDTH, NUM_CH);

  logic [PW-1:0] wr_ptr, rd_ptr, mark_ptr;
  logic [PW-1:0] wr_ptr_n, rd_ptr_n, mark_ptr_n;
  logic [CW-1:0] occ, rd_cnt, occ_n, rd_cnt_n;
  logic          mark_active, mark_active_n;
  logic          wr_acc, rd_acc;
  ctl_e          ctl;

  assign full      = (occ == CW'(DEPTH));
  assign empty     = (rd_cnt == '0);
  assign occupancy = occ;
  assign rd_count  = rd_cnt;

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty & ~rd_rewind;

  // A rewind without an active mark is a no-op and lets lower-priority pulses through.
  always_comb begin
    ctl = CTL_NONE;
    if (rd_rewind && mark_active)
      ctl = CTL_REWIND;
    else if (rd_release)
      ctl = CTL_RELEASE;
    else if (rd_mark)
      ctl = CTL_MARK;
  end

  always_comb begin
    wr_ptr_n      = wr_acc ? PW'(ptr_inc(32'(wr_ptr), DEPTH)) : wr_ptr;
    rd_ptr_n      = rd_acc ? PW'(ptr_inc(32'(rd_ptr), DEPTH)) : rd_ptr;
    mark_ptr_n    = mark_ptr;
    mark_active_n = mark_active;
    rd_cnt_n      = rd_cnt + CW'(wr_acc) - CW'(rd_acc);
    // Reads behind an active mark stay counted in occ until released.
    occ_n         = occ + CW'(wr_acc) - CW'(rd_acc & ~mark_active);
    case (ctl)
      CTL_REWIND: begin
        rd_ptr_n = mark_ptr;
        rd_cnt_n = occ + CW'(wr_acc);
      end
      CTL_RELEASE: begin
        mark_active_n = 1'b0;
        occ_n         = rd_cnt - CW'(rd_acc) + CW'(wr_acc);
      end
      CTL_MARK: begin
        mark_ptr_n    = rd_ptr;
        mark_active_n = 1'b1;
        occ_n         = rd_cnt + CW'(wr_acc);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      mark_ptr    <= '0;
      occ         <= '0;
      rd_cnt      <= '0;
      mark_active <= 1'b0;
      rd_valid    <= 1'b0;
      ovf         <= 1'b0;
      udf         <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_n;
      rd_ptr      <= rd_ptr_n;
      mark_ptr    <= mark_ptr_n;
      occ         <= occ_n;
      rd_cnt      <= rd_cnt_n;
      mark_active <= mark_active_n;
      rd_valid    <= rd_acc;
      if (wr_en && full)
        ovf <= 1'b1;
      if (rd_en && empty && !rd_rewind)
        udf <= 1'b1;
    end
  end

  fifo_sdp_ram #(
    .WIDTH (WW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_fifo_multi_ch.sv
// Directed bench: a DEPTH=8 and a DEPTH=6 instance share one stimulus stream.
module tb_fifo_multi_ch;

  localparam int DW  = 16;
  localparam int NCH = 4;
  localparam int WW  = DW * NCH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, wr_en, rd_en, rd_mark, rd_rewind, rd_release;
  logic [WW-1:0] wr_data;

  logic [WW-1:0] a_rd_data, b_rd_data;
  logic          a_rd_valid, a_full, a_empty, a_ovf, a_udf;
  logic          b_rd_valid, b_full, b_empty, b_ovf, b_udf;
  logic [3:0]    a_occ, a_rdc;
  logic [2:0]    b_occ, b_rdc;

  fifo_multi_ch #(.DATA_WIDTH(DW), .NUM_CH(NCH), .DEPTH(8)) dut8 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_mark(rd_mark), .rd_rewind(rd_rewind), .rd_release(rd_release),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .full(a_full), .empty(a_empty),
    .occupancy(a_occ), .rd_count(a_rdc), .ovf(a_ovf), .udf(a_udf)
  );

  fifo_multi_ch #(.DATA_WIDTH(DW), .NUM_CH(NCH), .DEPTH(6)) dut6 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_mark(rd_mark), .rd_rewind(rd_rewind), .rd_release(rd_release),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .full(b_full), .empty(b_empty),
    .occupancy(b_occ), .rd_count(b_rdc), .ovf(b_ovf), .udf(b_udf)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        w;
    logic [11:0] wv;
    logic        r;
    logic        v;
    logic [11:0] dv;
    logic        f;
    logic        e;
    int          occ;
    int          rc;
    logic        o;
    logic        u;
  } vec_t;

  vec_t tbl[$];

  // Lane k carries {k, v} so lane swaps are visible.
  function automatic logic [WW-1:0] mkw(input logic [11:0] v);
    logic [WW-1:0] w;
    for (int k = 0; k < NCH; k++)
      w[k*DW +: DW] = {4'(k), v};
    return w;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic [11:0] wv, input logic r,
                     input logic mk, input logic rw, input logic rl);
    wr_en      = w;
    wr_data    = mkw(wv);
    rd_en      = r;
    rd_mark    = mk;
    rd_rewind  = rw;
    rd_release = rl;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(0, 12'h0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic chk8(input string tag, input logic v, input logic [11:0] dv, input logic f,
                      input logic e, input int occ, input int rc, input logic o, input logic u);
    chk({tag, ".valid"}, 64'(a_rd_valid), 64'(v));
    chk({tag, ".data"},  a_rd_data, v ? mkw(dv) : 64'h0);
    chk({tag, ".full"},  64'(a_full), 64'(f));
    chk({tag, ".empty"}, 64'(a_empty), 64'(e));
    chk({tag, ".occ"},   64'(a_occ), 64'(occ));
    chk({tag, ".rdcnt"}, 64'(a_rdc), 64'(rc));
    chk({tag, ".ovf"},   64'(a_ovf), 64'(o));
    chk({tag, ".udf"},   64'(a_udf), 64'(u));
  endtask

  initial begin
    rst = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; rd_mark = 1'b0; rd_rewind = 1'b0; rd_release = 1'b0;
    wr_data = '0;

    // Fill, overflow, read at full, drain, underflow.
    for (int i = 1; i <= 8; i++)
      tbl.push_back('{1'b1, 12'(i), 1'b0, 1'b0, 12'h0, i == 8, 1'b0, i, i, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 12'hAAA, 1'b0, 1'b0, 12'h0, 1'b1, 1'b0, 8, 8, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 12'hBBB, 1'b1, 1'b1, 12'h1, 1'b0, 1'b0, 7, 7, 1'b1, 1'b0});
    for (int k = 2; k <= 8; k++)
      tbl.push_back('{1'b0, 12'h0, 1'b1, 1'b1, 12'(k), 1'b0, k == 8, 8 - k, 8 - k, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 12'h0, 1'b1, 1'b0, 12'h0, 1'b0, 1'b1, 0, 0, 1'b1, 1'b1});

    do_reset();
    chk8("reset", 0, 0, 0, 1, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].w, tbl[i].wv, tbl[i].r, 0, 0, 0);
      chk8($sformatf("vec%0d", i), tbl[i].v, tbl[i].dv, tbl[i].f, tbl[i].e,
           tbl[i].occ, tbl[i].rc, tbl[i].o, tbl[i].u);
    end

    // Mark, read, rewind, re-read, release.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 12'(12'hA + i), 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk8("mark", 0, 0, 0, 0, 4, 4, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 0, 0, 0);
      chk8($sformatf("mrd%0d", i), 1, 12'(12'hA + i), 0, i == 3, 4, 3 - i, 0, 0);
    end
    cyc(0, 0, 0, 0, 1, 0);
    chk8("rewind", 0, 0, 0, 0, 4, 4, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 0, 0, 0);
      chk8($sformatf("rrd%0d", i), 1, 12'(12'hA + i), 0, i == 3, 4, 3 - i, 0, 0);
    end
    cyc(0, 0, 0, 0, 0, 1);
    chk8("release", 0, 0, 0, 1, 0, 0, 0, 0);

    // Rewind coinciding with read and write.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 12'(12'h11 + i), 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk8("pre_rd0", 1, 12'h11, 0, 0, 5, 4, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk8("pre_rd1", 1, 12'h12, 0, 0, 5, 3, 0, 0);
    cyc(1, 12'h16, 1, 0, 1, 0);
    chk8("rw_rd_wr", 0, 0, 0, 0, 6, 6, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk8("after_rw", 1, 12'h11, 0, 0, 6, 5, 0, 0);

    // Reset mid-stream with a live mark and sticky udf.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 12'(12'h21 + i), 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk8("pre_rst", 0, 0, 0, 1, 3, 0, 0, 1);
    rst = 1'b1;
    cyc(1, 12'h30, 1, 0, 0, 0);
    rst = 1'b0;
    chk8("mid_rst", 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 12'h31, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk8("post_rst", 1, 12'h31, 0, 1, 0, 0, 0, 0);

    // DEPTH=6 streaming with one-cycle lag: pointers wrap several times.
    do_reset();
    for (int t = 0; t <= 20; t++) begin
      cyc(t < 20, 12'(12'h100 + t), t >= 1, 0, 0, 0);
      if (t >= 1) begin
        chk($sformatf("wrap_v%0d", t), 64'(b_rd_valid), 64'h1);
        chk($sformatf("wrap_d%0d", t), b_rd_data, mkw(12'(12'h100 + t - 1)));
      end
    end
    chk("wrap_ovf",   64'(b_ovf), 64'h0);
    chk("wrap_udf",   64'(b_udf), 64'h0);
    chk("wrap_empty", 64'(b_empty), 64'h1);
    chk("wrap_occ",   64'(b_occ), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_multi_ch.md
Name: fifo_multi_ch

Overview:
Parametrised multi-lane FIFO for the conv datapath. It stores NUM_CH lanes of DATA_WIDTH as one wide word per entry.
It adds full/empty/occupancy status and overflow/underflow flags. A mark/rewind/release replay mechanism lets the PE array re-read the same input window once per output filter without the producer re-sending it.
It sits between the input-feature loader and the PE array, replacing the single-lane FIFO for layer-1 and later layers.

Parameters:
DATA_WIDTH, 16, bits per lane
NUM_CH, 4, lanes per entry (all lanes written/read together)
DEPTH, 4608, entries; any value >= 2, not required to be a power of two
PW, $clog2(DEPTH), pointer width (derived, localparam)
CW, $clog2(DEPTH+1), count width (derived, localparam)

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  synchronous, active-high reset
wr_en  in  1  write request
wr_data  in  NUM_CH*DATA_WIDTH  write word, lane k at bits [k*DATA_WIDTH +: DATA_WIDTH]
rd_en  in  1  read request
rd_mark  in  1  pulse: set replay mark at current read pointer
rd_rewind  in  1  pulse: return read pointer to mark
rd_release  in  1  pulse: drop mark, free retained entries
rd_data  out  NUM_CH*DATA_WIDTH  read word, registered
rd_valid  out  1  rd_data holds an accepted read
full  out  1  occ == DEPTH
empty  out  1  rd_cnt == 0
occupancy  out  CW  occ (stored entries, including retained ones)
rd_count  out  CW  rd_cnt (entries still readable)
ovf  out  1  sticky: write attempted while full
udf  out  1  sticky: read attempted while empty

Behaviour:
- Reset (rst=1): wr_ptr = rd_ptr = mark_ptr = 0; occ = rd_cnt = 0; mark_active = 0; rd_data = 0; rd_valid = 0; ovf = udf = 0. This also applies mid-operation; RAM contents are not cleared.
- Pointers wrap explicitly: ptr == DEPTH-1 -> 0. No power-of-two assumption.
- Acceptance uses registered flags only; there is no write-to-read bypass:
  - wr_acc = wr_en & ~full
  - rd_acc = rd_en & ~empty & ~rd_rewind
- Write: on wr_acc, RAM[wr_ptr] <= wr_data; wr_ptr advances; rd_cnt +1; occ +1.
- Read, 1-cycle latency: on rd_acc, rd_data <= RAM[rd_ptr] next cycle edge; rd_valid = 1; rd_ptr advances; rd_cnt -1.
  - occ -1 only when mark_active = 0; retained entries stay counted.
  - Cycle without rd_acc: rd_data = 0, rd_valid = 0 (zero-when-idle, same as the existing FIFO).
- Mark: mark_ptr <= rd_ptr (pre-read value, so an entry read in the same cycle is retained); mark_active = 1; occ <= rd_cnt + wr_acc.
  - Re-mark while active moves the mark forward and frees entries behind it.
- Rewind (only when mark_active; ignored otherwise): rd_ptr <= mark_ptr; rd_cnt <= occ + wr_acc; mark stays active. A same-cycle rd_en is dropped (no udf).
- Release: mark_active = 0; occ <= rd_cnt - rd_acc + wr_acc.
- Control priority when pulses coincide: rst > rd_rewind > rd_release > rd_mark.
- Status:
  - full while occ == DEPTH; a write at full is ignored and sets ovf. Same-cycle read at full does not admit the write.
  - empty while rd_cnt == 0; a read at empty is ignored, sets udf, and leaves rd_valid = 0.
- Invariant: rd_cnt <= occ <= DEPTH at all times; occ == rd_cnt whenever mark_active = 0.

Decomposition:
- Package fifo_pkg: lane/word width helpers, a ptr_inc wrap function (ptr, DEPTH), and a control-priority enum {CTL_NONE, CTL_MARK, CTL_RELEASE, CTL_REWIND}.
- Sub-module fifo_sdp_ram (params WIDTH, DEPTH): simple dual-port RAM, one sync write port, one registered read port with read enable. Output forced to 0 when not enabled.
- Top module holds pointers, counters, mark logic, flags.

Test Plan:
- DEPTH=8, NUM_CH=4: write words 0x0001..0x0008 per lane -> full=1, occupancy=8. Read 8 -> data in order with 1-cycle latency, rd_valid each cycle, empty=1, occupancy=0.
- Fill to 8, then write 0xAAAA -> write ignored, ovf=1, occupancy stays 8. Read at empty -> udf=1, rd_data=0, rd_valid=0.
- Write 4 words A..D, mark, read 4 -> occupancy=4, rd_count=0. Rewind, read 4 -> A..D again. Release -> occupancy=0.
- DEPTH=6, write/read 20 words continuously with one-cycle lag -> pointer wraps 5->0 and all 20 words return in order, no flag errors.
- With mark active and occupancy=5: assert rd_rewind with rd_en and wr_en the same cycle -> read dropped, rd_count=6, occupancy=6, next read returns the marked entry.
- Assert rst mid-stream with 3 entries held and mark active -> the next cycle shows empty=1, occupancy=0, rd_valid=0, ovf=udf=0, mark inactive.
